// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; optional FETCH_ALIGN_CHECK_EN faults odd redirect targets into HALT.
// Latency: 1 cycle from imem_ready to IF/ID; a returned word is parked in a one-entry hold register during stall.
// Backpressure: stall freezes IF/ID and blocks new requests; outstanding requests always run to imem_ready.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        fetch_enable,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instruction,
    output logic [15:0] PC_2,
    output logic        valid,
    output logic        err
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] addr_q, addr_nxt;
    logic        halt_pending, halt_pending_nxt;
    logic        hold_valid, hold_valid_nxt;
    logic [15:0] hold_instr, hold_instr_nxt;
    logic [15:0] hold_pc2, hold_pc2_nxt;
    logic [15:0] instr_nxt, pc2_nxt;
    logic        valid_nxt;
    logic        err_q, err_nxt;
    logic        word_vld;
    logic [15:0] word_pc2;
    logic        redir_bad;
    logic [15:0] redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad    = redirect && redirect_pc[0] && (state != S_HALT);
    assign redir_target = redirect_pc;
`else
    assign redir_bad    = 1'b0;
    assign redir_target = redirect_pc & 16'hFFFE;
`endif

    assign err      = err_q;
    assign word_pc2 = imem_addr + 16'd2;

    // Fetch FSM: request generation and PC ownership.
    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        addr_nxt         = addr_q;
        halt_pending_nxt = halt_pending;
        err_nxt          = err_q | redir_bad;
        imem_rd          = 1'b0;
        imem_addr        = addr_q;
        word_vld         = 1'b0;

        case (state)
            S_FETCH: begin
                imem_addr = pc;
                if (!fetch_enable) begin
                    state_nxt = S_HALT;
                end else if (redirect) begin
                    if (redir_bad) state_nxt = S_HALT;
                    else           pc_nxt    = redir_target;
                end else if (!stall && !hold_valid) begin
                    imem_rd  = 1'b1;
                    addr_nxt = pc;
                    if (imem_ready) begin
                        word_vld = 1'b1;
                        pc_nxt   = pc + 16'd2;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                imem_rd = 1'b1;
                if (redirect) begin
                    if (redir_bad) halt_pending_nxt = 1'b1;
                    else           pc_nxt           = redir_target;
                    if (imem_ready) state_nxt = redir_bad ? S_HALT : S_FETCH;
                    else            state_nxt = S_DRAIN;
                end else if (!fetch_enable) begin
                    halt_pending_nxt = 1'b1;
                    state_nxt        = imem_ready ? S_HALT : S_DRAIN;
                end else if (imem_ready) begin
                    word_vld  = 1'b1;
                    pc_nxt    = pc + 16'd2;
                    state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                imem_rd = 1'b1;
                if (redirect) begin
                    if (redir_bad) halt_pending_nxt = 1'b1;
                    else           pc_nxt           = redir_target;
                end
                if (imem_ready) state_nxt = halt_pending_nxt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                imem_rd = 1'b0;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // An abandoned request is simply dropped; the memory tolerates it.
        if (rst) imem_rd = 1'b0;
    end

    // IF/ID update: redirect beats stall; fetch_enable low freezes the halt word in place.
    always_comb begin
        instr_nxt      = instruction;
        pc2_nxt        = PC_2;
        valid_nxt      = valid;
        hold_valid_nxt = hold_valid;
        hold_instr_nxt = hold_instr;
        hold_pc2_nxt   = hold_pc2;

        if (state == S_HALT) begin
            hold_valid_nxt = hold_valid;
        end else if (redirect) begin
            instr_nxt      = NOP_INSTR;
            valid_nxt      = 1'b0;
            hold_valid_nxt = 1'b0;
        end else if (stall || !fetch_enable) begin
            if (word_vld) begin
                hold_valid_nxt = 1'b1;
                hold_instr_nxt = imem_rdata;
                hold_pc2_nxt   = word_pc2;
            end
        end else if (hold_valid) begin
            instr_nxt      = hold_instr;
            pc2_nxt        = hold_pc2;
            valid_nxt      = 1'b1;
            hold_valid_nxt = 1'b0;
        end else if (word_vld) begin
            instr_nxt = imem_rdata;
            pc2_nxt   = word_pc2;
            valid_nxt = 1'b1;
        end else begin
            instr_nxt = NOP_INSTR;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            addr_q       <= RESET_PC;
            halt_pending <= 1'b0;
            hold_valid   <= 1'b0;
            hold_instr   <= NOP_INSTR;
            hold_pc2     <= 16'h0000;
            instruction  <= NOP_INSTR;
            PC_2         <= 16'h0000;
            valid        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            addr_q       <= addr_nxt;
            halt_pending <= halt_pending_nxt;
            hold_valid   <= hold_valid_nxt;
            hold_instr   <= hold_instr_nxt;
            hold_pc2     <= hold_pc2_nxt;
            instruction  <= instr_nxt;
            PC_2         <= pc2_nxt;
            valid        <= valid_nxt;
            err_q        <= err_nxt;
        end
    end

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (imem_rd && !imem_ready) |=> (rst || (imem_rd && $stable(imem_addr))));

endmodule
